// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, default frame constants
// and the three-sample majority vote used by the bit sampler.
package uart_pkg;

    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO: combinational head read, registered overrun pulse when
// a push arrives while full and no pop frees a slot in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop_req,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop;
    logic             push_ok;

    assign valid   = (count != '0);
    assign pop     = pop_req && valid;
    assign push_ok = push && ((count != FULL_COUNT) || pop);
    assign rd_data = mem[rd_ptr];

    // NOTE: storage is reset too, because the head is read straight from it and must be zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && !push_ok;
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (pop && !push_ok) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: synchronizes rx, frames start/data/stop bits with
// a majority vote around each bit centre, and queues good bytes in a FIFO.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            os_tick,
    input  logic                            rx,
    output logic [DATA_BITS-1:0]            rx_data,
    output logic                            rx_valid,
    input  logic                            rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
    output logic                            frame_err,
    output logic                            overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] START_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] SAMP_A    = TW'(OVERSAMPLE - 3);
    localparam logic [TW-1:0] SAMP_B    = TW'(OVERSAMPLE - 2);
    localparam logic [TW-1:0] BIT_END   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx_sync;
    logic [2:0]           state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic [1:0]           samples;
    logic                 bit_val;
    logic                 push;

    // NOTE: synchronizer flops reset to the idle level so reset release never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Bit centre sits one full bit after the previous decision; two earlier samples vote with the live one.
    assign bit_val = majority3(samples[0], samples[1], rx_sync);
    assign push    = (state == ST_STOP) && os_tick && (tick_cnt == BIT_END) && bit_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            samples   <= 2'b11;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (os_tick) begin
                case (state)
                    ST_IDLE: begin
                        if (!rx_sync) begin
                            state    <= ST_START;
                            tick_cnt <= '0;
                        end
                    end
                    ST_START: begin
                        if (tick_cnt == START_MID) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= rx_sync ? ST_IDLE : ST_DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    ST_DATA, ST_STOP: begin
                        if (tick_cnt == SAMP_A) samples[0] <= rx_sync;
                        if (tick_cnt == SAMP_B) samples[1] <= rx_sync;
                        if (tick_cnt == BIT_END) begin
                            tick_cnt <= '0;
                            if (state == ST_DATA) begin
                                shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
                                if (bit_cnt == LAST_BIT) state <= ST_STOP;
                                else                     bit_cnt <= bit_cnt + 1'b1;
                            end else if (bit_val) begin
                                state <= ST_IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= ST_BREAK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    ST_BREAK: begin
                        if (rx_sync) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shift_reg),
        .pop_req   (rx_ready),
        .rd_data   (rx_data),
        .valid     (rx_valid),
        .count     (rx_count),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed and randomized frame-level bench for uart_rx_core; expected FIFO
// contents and error pulse counts come from a queue-based model of the frames sent.
module tb_uart_rx_core;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);
    // Cycles from the start-bit fall to the stop decision with os_tick every cycle:
    // 2 sync stages, half a bit to the start midpoint, then DATA_BITS+1 full bits.
    localparam int PUSH_OFFSET = 2 + OVERSAMPLE / 2 + (DATA_BITS + 1) * OVERSAMPLE;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 os_tick;
    logic                 rx;
    logic                 rx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic [CW-1:0]        rx_count;
    logic                 frame_err;
    logic                 overrun;

    int vectors     = 0;
    int miscompares = 0;
    int fe_seen     = 0;
    int ov_seen     = 0;
    int exp_fe      = 0;
    int exp_ov      = 0;
    int tick_div    = 1;
    int phase       = 0;
    logic [DATA_BITS-1:0] exp_q [$];

    uart_rx_core #(
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .os_tick   (os_tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_count  (rx_count),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) phase <= (phase >= tick_div - 1) ? 0 : phase + 1;
    assign os_tick = (phase == 0);

    always @(posedge clk) begin
        if (frame_err === 1'b1) fe_seen <= fe_seen + 1;
        if (overrun === 1'b1)   ov_seen <= ov_seen + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge following the next os_tick posedge.
    task automatic wait_tick();
        logic t;
        do begin
            t = os_tick;
            @(negedge clk);
        end while (!t);
    endtask

    task automatic idle_ticks(input int n);
        rx = 1'b1;
        repeat (n) wait_tick();
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (OVERSAMPLE) wait_tick();
    endtask

    task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    // Frame-level reference: good frames queue if room, else count an overrun.
    task automatic frame(input logic [DATA_BITS-1:0] d, input logic stop);
        send_frame(d, stop);
        if (!stop)                          exp_fe++;
        else if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(d);
        else                                exp_ov++;
        if (!stop) idle_ticks(4);
    endtask

    task automatic check_state(input string tag);
        check({tag, " count"}, 32'(rx_count), exp_q.size());
        check({tag, " valid"}, 32'(rx_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) check({tag, " head"}, 32'(rx_data), 32'(exp_q[0]));
        check({tag, " frame_err pulses"}, fe_seen, exp_fe);
        check({tag, " overrun pulses"}, ov_seen, exp_ov);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() != 0) begin
            check({tag, " pop valid"}, 32'(rx_valid), 1);
            check({tag, " pop data"}, 32'(rx_data), 32'(exp_q[0]));
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
            void'(exp_q.pop_front());
        end
        check({tag, " drained count"}, 32'(rx_count), 0);
        check({tag, " drained valid"}, 32'(rx_valid), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rx_valid"}, 32'(rx_valid), 0);
        check({tag, " rx_count"}, 32'(rx_count), 0);
        check({tag, " rx_data"}, 32'(rx_data), 0);
        check({tag, " frame_err"}, 32'(frame_err), 0);
        check({tag, " overrun"}, 32'(overrun), 0);
    endtask

    initial begin
        logic [DATA_BITS-1:0] rnd_byte;
        logic                 rnd_stop;
        int                   n_frames;

        reset    = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        idle_ticks(8);

        // Single good frame.
        frame(8'hA5, 1'b1);
        check_state("a5");
        drain("a5");

        // Short low glitch must not start a frame; a following frame still decodes.
        rx = 1'b0;
        repeat (4) wait_tick();
        idle_ticks(24);
        check_state("glitch");
        frame(8'h5A, 1'b1);
        check_state("after glitch");
        drain("after glitch");

        // Framing error, break held low, then recovery.
        send_frame(8'h3C, 1'b0);
        exp_fe++;
        repeat (40) wait_tick();
        idle_ticks(6);
        check_state("framing error");
        frame(8'h81, 1'b1);
        check_state("after break");
        drain("after break");

        // Fill the FIFO and overrun it with a fifth byte.
        for (int i = 1; i <= 4; i++) frame(DATA_BITS'(i), 1'b1);
        check_state("full");
        frame(8'h05, 1'b1);
        check_state("overrun");
        drain("overrun");

        // Push into a full FIFO while popping in the same cycle.
        for (int i = 0; i < 4; i++) frame(DATA_BITS'(8'h11 + i), 1'b1);
        check_state("refill");
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (PUSH_OFFSET) @(negedge clk);
                check("push+pop head", 32'(rx_data), 32'h11);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        void'(exp_q.pop_front());
        exp_q.push_back(8'h55);
        check_state("push+pop");
        drain("push+pop");

        // rx_ready while empty does nothing.
        rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        rx_ready = 1'b0;
        check_state("ready empty");

        // Randomized frames, tick rates, gaps and occasional stop errors.
        for (int r = 0; r < 4; r++) begin
            tick_div = int'($urandom_range(1, 3));
            n_frames = int'($urandom_range(2, 6));
            for (int f = 0; f < n_frames; f++) begin
                rnd_byte = DATA_BITS'($urandom);
                rnd_stop = ($urandom_range(0, 7) != 0);
                frame(rnd_byte, rnd_stop);
                idle_ticks(int'($urandom_range(0, 5)));
            end
            idle_ticks(2);
            check_state($sformatf("random round %0d", r));
            drain($sformatf("random round %0d", r));
        end
        tick_div = 1;
        idle_ticks(4);

        // Reset during data bit 3 of 0xFF drops both the queue and the partial frame.
        frame(8'h77, 1'b1);
        check_state("pre-reset");
        send_bit(1'b0);
        repeat (3) send_bit(1'b1);
        rx = 1'b1;
        repeat (OVERSAMPLE / 2) wait_tick();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("mid-frame reset");
        exp_q.delete();
        reset = 1'b0;
        idle_ticks(OVERSAMPLE * 6);
        check_state("after reset idle");
        frame(8'h12, 1'b1);
        check_state("after reset 12");
        drain("after reset 12");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
